// File: rtl/exe_stage.sv
// Execute stage with its EXE/MEM register: ALU, address generation and combinational branch resolution.
// Optional macro EXE_MUL_EN adds opcode 17 (MUL, low WIDTH bits of X*Y); undefined, opcode 17 is unknown.
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-3:0]   PC_in,
    input  logic [WIDTH-1:0]   IR_in,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic [WIDTH-3:0]   PC_out,
    output logic [WIDTH-1:0]   IR_out,
    output logic [WIDTH-1:0]   Z,
    output logic [WIDTH-1:0]   Addr,
    output logic               IsBranch,
    output logic [WIDTH-3:0]   BranchAddr
);
    localparam int PW = WIDTH - 2;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_SLL  = 6'd6;
    localparam logic [5:0] OP_SRL  = 6'd7;
    localparam logic [5:0] OP_SRA  = 6'd8;
    localparam logic [5:0] OP_SLT  = 6'd9;
    localparam logic [5:0] OP_ADDI = 6'd10;
    localparam logic [5:0] OP_LUI  = 6'd11;
    localparam logic [5:0] OP_LD   = 6'd12;
    localparam logic [5:0] OP_ST   = 6'd13;
    localparam logic [5:0] OP_BEQ  = 6'd14;
    localparam logic [5:0] OP_BNE  = 6'd15;
    localparam logic [5:0] OP_JMP  = 6'd16;
`ifdef EXE_MUL_EN
    localparam logic [5:0] OP_MUL  = 6'd17;
`endif

    logic        [5:0]       op;
    logic        [WIDTH-1:0] simm;
    logic signed [WIDTH-1:0] x_s;
    logic signed [WIDTH-1:0] y_s;
    logic        [PW-1:0]    br_target;
    logic        [PW-1:0]    jmp_target;
    logic        [WIDTH-1:0] result;
    logic        [WIDTH-1:0] address;
    logic                    taken;
    logic        [PW-1:0]    target;

    logic [PW-1:0]    pc_out_q, pc_out_d;
    logic [WIDTH-1:0] ir_out_q, ir_out_d;
    logic [WIDTH-1:0] z_q,      z_d;
    logic [WIDTH-1:0] addr_q,   addr_d;

    assign op         = IR_in[WIDTH-1 -: 6];
    assign simm       = {{(WIDTH-16){IR_in[15]}}, IR_in[15:0]};
    assign x_s        = X;
    assign y_s        = Y;
    // Targets are word addresses and wrap at the PC width.
    assign br_target  = PC_in + PW'(1) + simm[PW-1:0];
    assign jmp_target = {PC_in[PW-1:26], IR_in[25:0]};

    always_comb begin
        result  = '0;
        address = '0;
        taken   = 1'b0;
        target  = br_target;
        case (op)
            OP_ADD:  result = X + Y;
            OP_SUB:  result = X - Y;
            OP_AND:  result = X & Y;
            OP_OR:   result = X | Y;
            OP_XOR:  result = X ^ Y;
            OP_SLL:  result = X << Y[4:0];
            OP_SRL:  result = X >> Y[4:0];
            OP_SRA:  result = x_s >>> Y[4:0];
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, (x_s < y_s)};
            OP_ADDI: result = X + simm;
            OP_LUI:  result = {IR_in[15:0], {(WIDTH-16){1'b0}}};
            OP_LD:   address = X + simm;
            OP_ST: begin
                address = X + simm;
                result  = Y;
            end
            OP_BEQ:  taken = (X == Y);
            OP_BNE:  taken = (X != Y);
            OP_JMP: begin
                taken  = 1'b1;
                target = jmp_target;
            end
`ifdef EXE_MUL_EN
            OP_MUL:  result = X * Y;
`endif
            default: ;
        endcase
    end

    // Redirect is suppressed while the pipeline is held in reset.
    assign IsBranch   = rst_n & taken;
    assign BranchAddr = IsBranch ? target : '0;

    always_comb begin
        pc_out_d = PC_in;
        ir_out_d = IR_in;
        z_d      = result;
        addr_d   = address;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out_q <= '0;
            ir_out_q <= '0;
            z_q      <= '0;
            addr_q   <= '0;
        end else begin
            pc_out_q <= pc_out_d;
            ir_out_q <= ir_out_d;
            z_q      <= z_d;
            addr_q   <= addr_d;
        end
    end

    assign PC_out = pc_out_q;
    assign IR_out = ir_out_q;
    assign Z      = z_q;
    assign Addr   = addr_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vectors plus randomized instructions against a reference model.
module tb_exe_stage;
    logic        clk;
    logic        rst_n;
    logic [29:0] PC_in;
    logic [31:0] IR_in;
    logic [31:0] X;
    logic [31:0] Y;
    logic [29:0] PC_out;
    logic [31:0] IR_out;
    logic [31:0] Z;
    logic [31:0] Addr;
    logic        IsBranch;
    logic [29:0] BranchAddr;

    int n_tests = 0;
    int n_fail  = 0;

    exe_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PC_in      (PC_in),
        .IR_in      (IR_in),
        .X          (X),
        .Y          (Y),
        .PC_out     (PC_out),
        .IR_out     (IR_out),
        .Z          (Z),
        .Addr       (Addr),
        .IsBranch   (IsBranch),
        .BranchAddr (BranchAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input logic [15:0] imm);
        logic [5:0] o;
        o = op[5:0];
        return {o, 10'd0, imm};
    endfunction

    // Reference model: architectural meaning of each opcode in plain arithmetic.
    function automatic logic [31:0] ref_z(input logic [31:0] ir, input logic [31:0] x, input logic [31:0] y);
        int         op;
        int         sh;
        logic [31:0] ones;
        op   = int'(ir[31:26]);
        sh   = int'(y[4:0]);
        ones = 32'hFFFF_FFFF;
        case (op)
            1:  return x + y;
            2:  return x + (~y + 32'd1);
            3:  return x & y;
            4:  return x | y;
            5:  return x ^ y;
            6:  return x << sh;
            7:  return x >> sh;
            8:  return (x >> sh) | (x[31] ? ~(ones >> sh) : 32'd0);
            9:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            10: return x + {{16{ir[15]}}, ir[15:0]};
            11: return {ir[15:0], 16'd0};
            13: return y;
`ifdef EXE_MUL_EN
            17: return 32'(longint'(x) * longint'(y));
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_addr(input logic [31:0] ir, input logic [31:0] x);
        int op;
        op = int'(ir[31:26]);
        if (op == 12 || op == 13) return x + {{16{ir[15]}}, ir[15:0]};
        return 32'd0;
    endfunction

    function automatic logic ref_taken(input logic [31:0] ir, input logic [31:0] x, input logic [31:0] y);
        int op;
        op = int'(ir[31:26]);
        return (op == 16) || (op == 14 && x == y) || (op == 15 && x != y);
    endfunction

    function automatic logic [29:0] ref_target(input logic [29:0] pc, input logic [31:0] ir,
                                               input logic [31:0] x, input logic [31:0] y);
        longint t;
        if (!ref_taken(ir, x, y)) return 30'd0;
        if (ir[31:26] == 6'd16) return {pc[29:26], ir[25:0]};
        t = longint'(pc) + 1 + longint'($signed(ir[15:0]));
        return t[29:0];
    endfunction

    // Called 1ns after a rising edge: drive, check redirect mid-cycle, check the register after the edge.
    task automatic drive_check(input string tag, input logic [29:0] pc, input logic [31:0] ir,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] ez, input logic [31:0] ea,
                               input logic eb, input logic [29:0] et);
        PC_in = pc;
        IR_in = ir;
        X     = x;
        Y     = y;
        #4;
        check({tag, ".isbr"}, {31'd0, IsBranch}, {31'd0, eb});
        check({tag, ".brad"}, {2'd0, BranchAddr}, {2'd0, et});
        @(posedge clk);
        #1;
        check({tag, ".z"},    Z, ez);
        check({tag, ".addr"}, Addr, ea);
        check({tag, ".ir"},   IR_out, ir);
        check({tag, ".pc"},   {2'd0, PC_out}, {2'd0, pc});
    endtask

    task automatic drive_model(input string tag, input logic [29:0] pc, input logic [31:0] ir,
                               input logic [31:0] x, input logic [31:0] y);
        drive_check(tag, pc, ir, x, y, ref_z(ir, x, y), ref_addr(ir, x),
                    ref_taken(ir, x, y), ref_target(pc, ir, x, y));
    endtask

    int ops[21] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 20, 33, 63};

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        logic [31:0] rir;
        int          rop;

        rst_n = 1'b0;
        PC_in = 30'd3;
        IR_in = mk(1, 16'd0);
        X     = 32'd5;
        Y     = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        check("rst.pc",   {2'd0, PC_out}, 32'd0);
        check("rst.ir",   IR_out, 32'd0);
        check("rst.z",    Z, 32'd0);
        check("rst.addr", Addr, 32'd0);
        check("rst.isbr", {31'd0, IsBranch}, 32'd0);
        IR_in = mk(16, 16'h0040);
        #1;
        check("rst.jmp_isbr", {31'd0, IsBranch}, 32'd0);
        IR_in = mk(1, 16'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel.z",  Z, 32'd12);
        check("rel.ir", IR_out, mk(1, 16'd0));
        check("rel.pc", {2'd0, PC_out}, 32'd3);

        drive_check("sub",  30'd1, mk(2, 16'd0),  32'd3, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b0, 30'd0);
        drive_check("sra",  30'd2, mk(8, 16'd0),  32'h8000_0000, 32'd4, 32'hF800_0000, 32'd0, 1'b0, 30'd0);
        drive_check("slt",  30'd3, mk(9, 16'd0),  32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 30'd0);
        drive_check("lui",  30'd4, mk(11, 16'h1234), 32'd0, 32'd0, 32'h1234_0000, 32'd0, 1'b0, 30'd0);
        drive_check("ld",   30'd5, mk(12, 16'hFFFC), 32'h100, 32'd0, 32'd0, 32'hFC, 1'b0, 30'd0);
        drive_check("st",   30'd6, mk(13, 16'd4), 32'h10, 32'hAB, 32'hAB, 32'h14, 1'b0, 30'd0);
        drive_check("beq",  30'd10, mk(14, 16'd5), 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 30'd16);
        drive_check("bne",  30'd10, mk(15, 16'd5), 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 30'd0);
        drive_check("beqw", 30'd0, mk(14, 16'hFFFF), 32'd4, 32'd4, 32'd0, 32'd0, 1'b1, 30'd0);
        drive_check("jmp",  30'd0, mk(16, 16'h0040), 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, 30'h40);
        drive_check("halt", 30'h1234, {6'd63, 26'h3AB_CDEF}, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 30'd0);
        drive_check("op20", 30'h2BCD, {6'd20, 26'h155_5555}, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 30'd0);
`ifdef EXE_MUL_EN
        drive_check("mulw", 30'd7, mk(17, 16'd0), 32'h10000, 32'h10000, 32'd0, 32'd0, 1'b0, 30'd0);
        drive_check("mul",  30'd8, mk(17, 16'd0), 32'd6, 32'd7, 32'd42, 32'd0, 1'b0, 30'd0);
`else
        drive_check("mul",  30'd8, mk(17, 16'd0), 32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 30'd0);
`endif

        // Asynchronous reset in the middle of a stream.
        drive_check("pre", 30'd9, mk(1, 16'd0), 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 30'd0);
        rst_n = 1'b0;
        #1;
        check("arst.z",  Z, 32'd0);
        check("arst.ir", IR_out, 32'd0);
        check("arst.pc", {2'd0, PC_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arel.z", Z, 32'd12);

        for (int i = 0; i < 400; i++) begin
            rop = ops[$urandom_range(0, 20)];
            rx  = $urandom;
            ry  = ($urandom_range(0, 1) == 1) ? rx : $urandom;
            rir = {rop[5:0], 26'($urandom)};
            drive_model("rnd", 30'($urandom), rir, rx, ry);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
